// File: rtl/booth_pkg.sv
// Shared types and arithmetic helpers for the Booth multiply-accumulate slice.
package booth_pkg;

  localparam int OP_W      = 16;
  localparam int PROD_W    = 32;
  // Widest accumulator the shared saturating adder supports.
  localparam int ACC_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [ACC_MAX_W-1:0] sum;
    logic                        ovf;
  } sat_res_t;

  // Adds a product to an accumulator holding a sign-extended acc_w-bit value.
  // The sum is formed one bit wider than the accumulator so that overflow
  // beyond the signed acc_w range is detected exactly. The clamp is applied
  // only when sat_en is set; ovf is reported either way.
  function automatic sat_res_t sat_add(
    input logic signed [ACC_MAX_W-1:0] acc,
    input logic signed [PROD_W-1:0]    prod,
    input int                          acc_w,
    input logic                        sat_en
  );
    logic signed [ACC_MAX_W:0] w_sum;
    logic signed [ACC_MAX_W:0] w_max;
    logic signed [ACC_MAX_W:0] w_min;
    sat_res_t                  res;
    w_sum = {acc[ACC_MAX_W-1], acc}
          + {{(ACC_MAX_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    w_max = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    w_min = -w_max - 65'sd1;
    res.ovf = (w_sum > w_max) || (w_sum < w_min);
    if (res.ovf && sat_en) begin
      res.sum = (w_sum > w_max) ? w_max[ACC_MAX_W-1:0] : w_min[ACC_MAX_W-1:0];
    end else begin
      res.sum = w_sum[ACC_MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/boothmul.sv
// Combinational 16x16 signed radix-4 Booth multiplier.
module boothmul
  import booth_pkg::*;
(
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [PROD_W-1:0] p
);

  logic        [OP_W:0]     w_bx;
  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_pp;
  logic signed [PROD_W-1:0] w_sum;

  // Recode the multiplier in overlapping 3-bit groups and sum the partial products.
  always_comb begin
    w_bx    = {b, 1'b0};
    w_a_ext = PROD_W'(a);
    w_pp    = '0;
    w_sum   = '0;
    for (int i = 0; i < OP_W / 2; i++) begin
      case (w_bx[2*i +: 3])
        3'b001, 3'b010: w_pp = w_a_ext;
        3'b011:         w_pp = w_a_ext <<< 1;
        3'b100:         w_pp = -(w_a_ext <<< 1);
        3'b101, 3'b110: w_pp = -w_a_ext;
        default:        w_pp = '0;
      endcase
      w_sum = w_sum + (w_pp <<< (2 * i));
    end
    p = w_sum;
  end

endmodule

// File: rtl/booth_mac_acc.sv
// Burst multiply-accumulate: operand pairs -> boothmul -> wide signed accumulator.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [OP_W-1:0]  in_a,
  input  logic signed [OP_W-1:0]  in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat,
  output logic                    busy
);

  if (ACC_W < PROD_W || ACC_W > ACC_MAX_W) begin : g_bad_acc_w
    $error("booth_mac_acc: ACC_W must be in [32, 64]");
  end

  state_t                    r_state;
  logic [7:0]                r_remaining;
  logic signed [OP_W-1:0]    r_a_p1;
  logic signed [OP_W-1:0]    r_b_p1;
  logic                      r_vld_p1;
  logic signed [PROD_W-1:0]  r_prod_p2;
  logic                      r_vld_p2;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_sat;

  logic                      w_xfer;
  logic signed [PROD_W-1:0]  w_prod;
  sat_res_t                  w_res;

  assign in_ready  = (r_state == ACCUM) && (r_remaining != 8'd0);
  assign w_xfer    = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_acc   = r_acc;
  assign out_sat   = r_sat;

  assign w_res = sat_add(ACC_MAX_W'(r_acc), r_prod_p2, ACC_W, SAT_EN);

  // Upper adder bits beyond ACC_W are sign copies and intentionally dropped.
  if (ACC_W < ACC_MAX_W) begin : g_drop_hi
    logic w_unused;
    assign w_unused = ^w_res.sum[ACC_MAX_W-1:ACC_W];
  end

  // Burst control: count accepted pairs, then wait for the pipeline to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_remaining <= len;
            r_state     <= (len != 8'd0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!r_vld_p1 && !r_vld_p2) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: registered operands ----
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_xfer;
    if (w_xfer) begin
      r_a_p1 <= in_a;
      r_b_p1 <= in_b;
    end
  end

  boothmul u_mul (
    .a (r_a_p1),
    .b (r_b_p1),
    .p (w_prod)
  );

  // ---- stage p2: registered product ----
  always_ff @(posedge clk) begin
    if (rst) r_vld_p2 <= 1'b0;
    else     r_vld_p2 <= r_vld_p1;
    r_prod_p2 <= w_prod;
  end

  // ---- accumulate stage: cleared at burst start, sticky overflow flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (r_vld_p2) begin
      r_acc <= w_res.sum[ACC_W-1:0];
      r_sat <= r_sat | w_res.ovf;
    end
  end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: one 40-bit saturating instance plus
// 32-bit saturating and wrapping instances sharing the same stimulus.
module tb_booth_mac_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [7:0]         len;
  logic               in_valid;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               out_ready;

  logic               in_ready, out_valid, out_sat, busy;
  logic signed [39:0] out_acc;
  logic               rdy_s, vld_s, sat_s, busy_s;
  logic signed [31:0] acc_s;
  logic               rdy_w, vld_w, sat_w, busy_w;
  logic signed [31:0] acc_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mac_acc #(.ACC_W(40), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat), .busy(busy));

  booth_mac_acc #(.ACC_W(32), .SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy_s), .in_a(in_a), .in_b(in_b), .out_valid(vld_s),
    .out_ready(out_ready), .out_acc(acc_s), .out_sat(sat_s), .busy(busy_s));

  booth_mac_acc #(.ACC_W(32), .SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(rdy_w), .in_a(in_a), .in_b(in_b), .out_valid(vld_w),
    .out_ready(out_ready), .out_acc(acc_w), .out_sat(sat_w), .busy(busy_w));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  // Presents one pair and returns just after the edge that accepts it.
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
    int cnt;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      step();
      cnt++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_ready: in_ready=%0b required=1 after %0d cycles", in_ready, cnt);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_done: out_valid=%0b required=1 (timeout)", out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL consume: out_valid=%0b busy=%0b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_sat, busy} !== 4'b0000 || out_acc !== 40'sd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%0b vld=%0b sat=%0b busy=%0b acc=%0d required all 0",
               in_ready, out_valid, out_sat, busy, out_acc);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_pair();
    begin_burst(8'd1);
    send(16'sd3, -16'sd5);
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (out_valid !== (k == 3)) begin
        failures++;
        $display("FAIL single_latency: cycle %0d out_valid=%0b required=%0b", k, out_valid, (k == 3));
      end
    end
    checks++;
    if (out_acc !== -40'sd15 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL single_value: acc=%0d sat=%0b required -15/0", out_acc, out_sat);
    end
    consume();
  endtask

  task automatic test_max_gaps_and_overflow();
    begin_burst(8'd4);
    for (int k = 0; k < 4; k++) begin
      send(-16'sd32768, -16'sd32768);
      if (k < 3) begin
        step();
        step();
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_drop: in_ready=%0b required=0 after last transfer", in_ready);
    end
    wait_done();
    checks++;
    if (out_acc !== 40'sh01_0000_0000 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL acc40_2pow32: acc=%h sat=%0b required 0100000000/0", out_acc, out_sat);
    end
    checks++;
    if (vld_s !== 1'b1 || acc_s !== 32'sh7FFF_FFFF || sat_s !== 1'b1) begin
      failures++;
      $display("FAIL acc32_sat: vld=%0b acc=%h sat=%0b required 1/7fffffff/1", vld_s, acc_s, sat_s);
    end
    checks++;
    if (vld_w !== 1'b1 || acc_w !== 32'sh0000_0000 || sat_w !== 1'b1) begin
      failures++;
      $display("FAIL acc32_wrap: vld=%0b acc=%h sat=%0b required 1/00000000/1", vld_w, acc_w, sat_w);
    end
    consume();
  endtask

  task automatic test_len_zero_hold();
    begin_burst(8'd0);
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 40'sd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL len0_done: vld=%0b acc=%0d busy=%0b required 1/0/1", out_valid, out_acc, busy);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_acc !== 40'sd0 || out_sat !== 1'b0) begin
        failures++;
        $display("FAIL len0_hold: cycle %0d vld=%0b acc=%0d sat=%0b required 1/0/0",
                 k, out_valid, out_acc, out_sat);
      end
    end
    consume();
  endtask

  task automatic test_mixed_signs();
    begin_burst(8'd3);
    send(16'sd100, 16'sd200);
    start = 1'b1;
    len   = 8'd5;
    step();
    start = 1'b0;
    send(-16'sd7, 16'sd9);
    send(-16'sd1, -16'sd1);
    wait_done();
    checks++;
    if (out_acc !== 40'sd19938 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL mixed_value: acc=%0d sat=%0b required 19938/0", out_acc, out_sat);
    end
    // start together with the result handshake must not launch a burst
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_acc !== 40'sd19938) begin
      failures++;
      $display("FAIL done_start_ignored: busy=%0b vld=%0b acc=%0d required 0/0/19938",
               busy, out_valid, out_acc);
    end
  endtask

  task automatic test_reset_mid_burst();
    begin_burst(8'd4);
    send(16'sd1000, 16'sd1000);
    send(16'sd1000, 16'sd1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_sat, busy} !== 4'b0000 || out_acc !== 40'sd0) begin
      failures++;
      $display("FAIL reset_mid: rdy=%0b vld=%0b sat=%0b busy=%0b acc=%0d required all 0",
               in_ready, out_valid, out_sat, busy, out_acc);
    end
    step();
    step();
    checks++;
    if (out_acc !== 40'sd0) begin
      failures++;
      $display("FAIL reset_residue: acc=%0d required 0", out_acc);
    end
    begin_burst(8'd1);
    send(16'sd2, 16'sd2);
    wait_done();
    checks++;
    if (out_acc !== 40'sd4 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: acc=%0d sat=%0b required 4/0", out_acc, out_sat);
    end
    consume();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = 8'd0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_pair();
    test_max_gaps_and_overflow();
    test_len_zero_hold();
    test_mixed_signs();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
